// File: rtl/traffic_phase_scheduler_if.sv
// Request/emergency inputs and phase outputs of the intersection scheduler.
// The controller side drives requests; the scheduler drives the lights.
interface traffic_phase_scheduler_if;
    logic [3:0] req;
    logic       emg_valid;
    logic [1:0] emg_dir;
    logic [1:0] traffic_light;
    logic       green;
    logic       yellow;
    logic       all_red;
    logic       emg_active;

    modport master (
        output req, emg_valid, emg_dir,
        input  traffic_light, green, yellow, all_red, emg_active
    );

    modport slave (
        input  req, emg_valid, emg_dir,
        output traffic_light, green, yellow, all_red, emg_active
    );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Four-way intersection phase sequencer: timed green/yellow/all-red cycle,
// round-robin direction selection and emergency preemption.
module traffic_phase_scheduler #(
    parameter int unsigned GREEN_CYCLES   = 20,
    parameter int unsigned YELLOW_CYCLES  = 4,
    parameter int unsigned ALL_RED_CYCLES = 2,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    traffic_phase_scheduler_if.slave   bus
);

    localparam logic [CNT_W-1:0] G_LOAD = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] Y_LOAD = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] R_LOAD = CNT_W'(ALL_RED_CYCLES - 1);

    typedef enum logic [1:0] {
        S_GREEN,
        S_YELLOW,
        S_ALL_RED,
        S_EMG
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [1:0]       dir;
    logic [1:0]       dir_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;

    logic [1:0]       tl_n;
    logic             green_n;
    logic             yellow_n;
    logic             all_red_n;
    logic             emg_n;

    logic             cnt_zero;
    logic             other_req;
    logic             emg_here;

    // First requester after cur, circularly, cur itself last; cur+1 if none.
    function automatic logic [1:0] pick_dir(
        input logic [1:0] cur,
        input logic [3:0] r
    );
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = cur + 2'd1;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = cur + 2'(k);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign cnt_zero  = (cnt == '0);
    assign other_req = |(bus.req & ~(4'b0001 << dir));
    assign emg_here  = bus.emg_valid && (bus.emg_dir == dir);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_ALL_RED;
            dir   <= 2'd3;
            cnt   <= R_LOAD;
        end else begin
            state <= state_n;
            dir   <= dir_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        dir_n   = dir;
        cnt_n   = cnt - 1'b1;
        unique case (state)
            S_GREEN: begin
                if (bus.emg_valid) begin
                    if (emg_here) begin
                        state_n = S_EMG;
                        cnt_n   = cnt;
                    end else begin
                        state_n = S_YELLOW;
                        cnt_n   = Y_LOAD;
                    end
                end else if (cnt_zero) begin
                    if (other_req) begin
                        state_n = S_YELLOW;
                        cnt_n   = Y_LOAD;
                    end else begin
                        cnt_n   = G_LOAD;
                    end
                end
            end
            S_YELLOW: begin
                if (cnt_zero) begin
                    state_n = S_ALL_RED;
                    cnt_n   = R_LOAD;
                end
            end
            S_ALL_RED: begin
                if (cnt_zero) begin
                    if (bus.emg_valid) begin
                        state_n = S_EMG;
                        dir_n   = bus.emg_dir;
                        cnt_n   = cnt;
                    end else begin
                        state_n = S_GREEN;
                        dir_n   = pick_dir(dir, bus.req);
                        cnt_n   = G_LOAD;
                    end
                end
            end
            S_EMG: begin
                cnt_n = cnt;
                if (!emg_here) begin
                    state_n = S_YELLOW;
                    cnt_n   = Y_LOAD;
                end
            end
            default: begin
                state_n = S_ALL_RED;
                cnt_n   = R_LOAD;
            end
        endcase
    end

    // Decoded from the next state so the lights come straight from flops.
    always_comb begin
        tl_n      = dir_n;
        green_n   = (state_n == S_GREEN) || (state_n == S_EMG);
        yellow_n  = (state_n == S_YELLOW);
        all_red_n = (state_n == S_ALL_RED);
        emg_n     = (state_n == S_EMG);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.traffic_light <= 2'd3;
            bus.green         <= 1'b0;
            bus.yellow        <= 1'b0;
            bus.all_red       <= 1'b1;
            bus.emg_active    <= 1'b0;
        end else begin
            bus.traffic_light <= tl_n;
            bus.green         <= green_n;
            bus.yellow        <= yellow_n;
            bus.all_red       <= all_red_n;
            bus.emg_active    <= emg_n;
        end
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed vector bench for traffic_phase_scheduler: phase timing,
// round-robin selection, emergency preemption and mid-phase reset.
module tb_traffic_phase_scheduler;

    localparam int PG = 0;
    localparam int PY = 1;
    localparam int PR = 2;
    localparam int PE = 3;
    localparam int NV = 64;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       ev;
        logic [1:0] ed;
        int         cyc;
        logic [1:0] tl;
        int         ph;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bit   armed;

    vec_t vt [NV];
    int   nv;

    traffic_phase_scheduler_if bus ();

    traffic_phase_scheduler #(
        .GREEN_CYCLES   (20),
        .YELLOW_CYCLES  (4),
        .ALL_RED_CYCLES (2),
        .CNT_W          (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Invariant on every cycle once reset has been applied.
    always @(negedge clk) begin
        if (armed) begin
            checks++;
            if ((32'($countones({bus.green, bus.yellow, bus.all_red})) != 1)
                || (bus.emg_active && !bus.green)) begin
                errors++;
                $display("FAIL onehot t=%0t got g=%b y=%b r=%b e=%b want one-hot, e->g",
                         $time, bus.green, bus.yellow, bus.all_red,
                         bus.emg_active);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic v(input logic r, input logic [3:0] q, input logic e,
                     input logic [1:0] d, input int c, input logic [1:0] tl,
                     input int ph);
        vt[nv].rst = r;
        vt[nv].req = q;
        vt[nv].ev  = e;
        vt[nv].ed  = d;
        vt[nv].cyc = c;
        vt[nv].tl  = tl;
        vt[nv].ph  = ph;
        nv++;
    endtask

    function automatic logic [5:0] expect_bits(input logic [1:0] tl,
                                               input int ph);
        return {tl, (ph == PG || ph == PE), (ph == PY), (ph == PR),
                (ph == PE)};
    endfunction

    task automatic check(input string name, input logic [5:0] want);
        logic [5:0] got;
        got = {bus.traffic_light, bus.green, bus.yellow, bus.all_red,
               bus.emg_active};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got tl=%0d gyre=%b want tl=%0d gyre=%b",
                     name, got[5:4], got[3:0], want[5:4], want[3:0]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    initial begin
        int w;
        int n;
        checks = 0;
        errors = 0;
        armed  = 1'b0;
        nv     = 0;
        rst    = 1'b1;
        bus.req       = 4'd0;
        bus.emg_valid = 1'b0;
        bus.emg_dir   = 2'd0;

        // idle intersection: dir 0 green, extended
        v(1, 4'b0000, 0, 0,  2, 3, PR);
        v(0, 4'b0000, 0, 0,  0, 3, PR);
        v(0, 4'b0000, 0, 0,  1, 3, PR);
        v(0, 4'b0000, 0, 0,  1, 0, PG);
        v(0, 4'b0000, 0, 0, 19, 0, PG);
        v(0, 4'b0000, 0, 0,  1, 0, PG);
        v(0, 4'b0000, 0, 0, 20, 0, PG);
        // single requester on 2, then round robin over 3,0,2
        v(1, 4'b0100, 0, 0,  1, 3, PR);
        v(0, 4'b0100, 0, 0,  2, 2, PG);
        v(0, 4'b0100, 0, 0, 19, 2, PG);
        v(0, 4'b0100, 0, 0,  1, 2, PG);
        v(0, 4'b1101, 0, 0, 19, 2, PG);
        v(0, 4'b1101, 0, 0,  1, 2, PY);
        v(0, 4'b1101, 0, 0,  3, 2, PY);
        v(0, 4'b1101, 0, 0,  1, 2, PR);
        v(0, 4'b1101, 0, 0,  1, 2, PR);
        v(0, 4'b1101, 0, 0,  1, 3, PG);
        v(0, 4'b1101, 0, 0, 19, 3, PG);
        v(0, 4'b1101, 0, 0,  1, 3, PY);
        v(0, 4'b1101, 0, 0,  6, 0, PG);
        v(0, 4'b1101, 0, 0, 26, 2, PG);
        // emergency matching the green direction
        v(1, 4'b0010, 0, 0,  1, 3, PR);
        v(0, 4'b0010, 0, 0, 11, 1, PG);
        v(0, 4'b0010, 1, 1,  1, 1, PE);
        v(0, 4'b0010, 1, 1, 99, 1, PE);
        v(0, 4'b1010, 0, 1,  1, 1, PY);
        v(0, 4'b1010, 0, 1,  3, 1, PY);
        v(0, 4'b1010, 0, 1,  1, 1, PR);
        v(0, 4'b1010, 0, 1,  2, 3, PG);
        // emergency elsewhere, then redirected while held
        v(1, 4'b0000, 0, 0,  1, 3, PR);
        v(0, 4'b0000, 0, 0,  2, 0, PG);
        v(0, 4'b0000, 1, 2,  1, 0, PY);
        v(0, 4'b0000, 1, 2,  3, 0, PY);
        v(0, 4'b0000, 1, 2,  1, 0, PR);
        v(0, 4'b0000, 1, 2,  1, 0, PR);
        v(0, 4'b0000, 1, 2,  1, 2, PE);
        v(0, 4'b0000, 1, 2, 10, 2, PE);
        v(0, 4'b0000, 1, 3,  1, 2, PY);
        v(0, 4'b0000, 1, 3,  4, 2, PR);
        v(0, 4'b0000, 1, 3,  2, 3, PE);
        v(0, 4'b0000, 0, 3,  1, 3, PY);
        v(1, 4'b0000, 0, 3,  1, 3, PR);
        // reset in the middle of yellow
        v(0, 4'b0000, 0, 0,  2, 0, PG);
        v(0, 4'b0000, 1, 1,  2, 0, PY);
        v(1, 4'b0000, 0, 0,  1, 3, PR);
        v(0, 4'b0000, 0, 0,  1, 3, PR);

        step(1);
        for (int i = 0; i < nv; i++) begin
            rst           = vt[i].rst;
            bus.req       = vt[i].req;
            bus.emg_valid = vt[i].ev;
            bus.emg_dir   = vt[i].ed;
            step(vt[i].cyc);
            if (rst) armed = 1'b1;
            check($sformatf("vec%0d", i), expect_bits(vt[i].tl, vt[i].ph));
        end

        // exact phase lengths on a natural green->yellow->all-red rotation
        rst     = 1'b1;
        bus.req = 4'b0011;
        bus.emg_valid = 1'b0;
        step(1);
        rst = 1'b0;
        w = 0;
        while (!bus.green && w < 10) begin
            step(1);
            w++;
        end
        check_int("green_start", w, 2);
        n = 0;
        while (bus.green && n < 100) begin
            step(1);
            n++;
        end
        check_int("green_len", n, 20);
        n = 0;
        while (bus.yellow && n < 100) begin
            step(1);
            n++;
        end
        check_int("yellow_len", n, 4);
        n = 0;
        while (bus.all_red && n < 100) begin
            step(1);
            n++;
        end
        check_int("all_red_len", n, 2);
        check("next_dir", expect_bits(2'd1, PG));

        // reset pulse during green aborts immediately
        step(5);
        rst = 1'b1;
        step(1);
        check("rst_green", expect_bits(2'd3, PR));
        rst = 1'b0;
        step(2);
        check("after_rst", expect_bits(2'd0, PG));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
